// File: rtl/counter_sched.sv
// counter_sched
//
// Purpose:
//   Sequences INC / LOAD commands from two requesters onto an external
//   4-bit counter datapath. Requesters are arbitrated round-robin, one command
//   is in flight at a time, and each command runs INIT/IDLE -> ISSUE ->
//   (SETTLE x SETTLE_CYC) -> CHECK. In CHECK the datapath output is compared
//   against a shadow copy of the expected count and a one-cycle response is
//   produced.
//
// Parameters:
//   SETTLE_CYC  idle cycles between issue and check (0..7)
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous active-low reset
//   req0_valid/op/data  requester 0 command (op 0=INC, 1=LOAD; data = LOAD value)
//   req0_ready          requester 0 command accepted when high with req0_valid
//   req1_*              same for requester 1
//   ctr_en              datapath increment enable
//   ctr_rst             datapath load strobe (active high)
//   ctr_ui              datapath load value
//   ctr_out             datapath result
//   rsp_valid           one-cycle response pulse
//   rsp_id              requester the response belongs to
//   rsp_data            sampled ctr_out
//   rsp_err             ctr_out differed from the shadow value
//   err_sticky          set by any rsp_err, cleared only by reset
//   done_cnt            completed command count (wraps)

module counter_sched #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_op,
    input  logic [3:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_op,
    input  logic [3:0] req1_data,
    output logic       req1_ready,
    output logic       ctr_en,
    output logic       ctr_rst,
    output logic [3:0] ctr_ui,
    input  logic [3:0] ctr_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic       err_sticky,
    output logic [7:0] done_cnt
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_CHECK
    } state_t;

    // Value the settle counter starts from; it counts down to zero while in
    // SETTLE, so a start of N-1 gives exactly N SETTLE cycles.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t     state;
    state_t     state_nxt;

    logic       last_grant;
    logic       cmd_op;
    logic       cmd_id;
    logic [3:0] cmd_data;
    logic [3:0] shadow;
    logic [3:0] settle_cnt;

    logic       rsp_id_q;
    logic [3:0] rsp_data_q;
    logic       rsp_err_q;

    logic       grant0;
    logic       grant1;
    logic       in_idle;
    logic       accept;
    logic       check_live;
    logic       mismatch;

    // Round-robin: on a tie the requester that did not win last time gets the
    // grant. Ready is suppressed while reset is asserted so nothing can be
    // accepted on a reset edge.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        in_idle    = rst && (state == S_IDLE);
        req0_ready = in_idle && grant0;
        req1_ready = in_idle && grant1;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Next state and datapath controls. Reset overrides everything so the
    // datapath is held in its load-zero state for the whole reset window.
    always_comb begin
        state_nxt = state;
        ctr_en    = 1'b0;
        ctr_rst   = 1'b0;
        ctr_ui    = 4'h0;
        case (state)
            S_INIT: begin
                ctr_rst   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_op) begin
                    ctr_rst = 1'b1;
                    ctr_ui  = cmd_data;
                end else begin
                    ctr_en  = 1'b1;
                end
                state_nxt = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
        if (!rst) begin
            ctr_en    = 1'b0;
            ctr_rst   = 1'b1;
            ctr_ui    = 4'h0;
            state_nxt = S_INIT;
        end
    end

    // The response is live during CHECK itself; outside CHECK the registered
    // copy of the last response is shown so the fields hold their values.
    always_comb begin
        check_live = rst && (state == S_CHECK);
        mismatch   = (ctr_out != shadow);
        rsp_valid  = check_live;
        rsp_id     = check_live ? cmd_id   : rsp_id_q;
        rsp_data   = check_live ? ctr_out  : rsp_data_q;
        rsp_err    = check_live ? mismatch : rsp_err_q;
    end

    // State register plus command latch, shadow count, settle timer and the
    // response/statistics registers. A reset mid-command simply discards the
    // latched command, so no response is produced for it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_INIT;
            last_grant <= 1'b1;
            cmd_op     <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_data   <= 4'h0;
            shadow     <= 4'h0;
            settle_cnt <= 4'd0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 4'h0;
            rsp_err_q  <= 1'b0;
            err_sticky <= 1'b0;
            done_cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_INIT: begin
                    shadow <= 4'h0;
                end
                S_IDLE: begin
                    if (accept) begin
                        cmd_op     <= req1_ready ? req1_op   : req0_op;
                        cmd_data   <= req1_ready ? req1_data : req0_data;
                        cmd_id     <= req1_ready;
                        last_grant <= req1_ready;
                    end
                end
                S_ISSUE: begin
                    shadow     <= cmd_op ? cmd_data : shadow + 4'd1;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    rsp_id_q   <= cmd_id;
                    rsp_data_q <= ctr_out;
                    rsp_err_q  <= mismatch;
                    err_sticky <= err_sticky | mismatch;
                    done_cnt   <= done_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
